// File: rtl/forward_north_south_pkg.sv
// Shared router constants: dy field geometry, per-direction hop step and merge source indices.
package forward_north_south_pkg;
  localparam int PACKET_WIDTH_DEF = 21;
  localparam int DY_MSB_DEF       = 20;
  localparam int DY_W             = 9;
  localparam int DY_LSB_DEF       = DY_MSB_DEF - DY_W + 1;
  localparam int ADD_NORTH        = -1;
  localparam int ADD_SOUTH        = 1;
  localparam int NUM_SRC          = 3;

  localparam logic [1:0] SRC_ROUTING = 2'd0;
  localparam logic [1:0] SRC_EAST    = 2'd1;
  localparam logic [1:0] SRC_WEST    = 2'd2;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_WEST) ? SRC_ROUTING : s + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_buffer.sv
// Generic synchronous FIFO, registered read: i_rd_en in cycle N presents the head on o_dout in N+1.
// Writes while full and reads while empty are ignored; almost_full flags one free slot left.
module fifo_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr       = i_wr_en && !o_full;
  assign w_do_rd       = i_rd_en && !o_empty;
  assign o_empty       = (r_count == '0);
  assign o_full        = (r_count == (AW+1)'(DEPTH));
  assign o_almost_full = (r_count == (AW+1)'(DEPTH - 1));
  assign o_dout        = r_dout;

  always_ff @(posedge i_clk) begin
    if (w_do_wr && !i_rst) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
    end
  end
endmodule

// File: rtl/forward_north_south_rr_merge3.sv
// Three-way round-robin read arbiter over registered-read source FIFOs plus the capture register.
// A grant in cycle N yields o_vld/o_dat in N+1; i_stall suppresses all grants and holds the pointer.
module rr_merge3 import forward_north_south_pkg::*; #(
  parameter int DATA_WIDTH = 21
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] i_din,
  input  logic [NUM_SRC-1:0]                 i_empty,
  input  logic                               i_stall,
  output logic [NUM_SRC-1:0]                 o_ren,
  output logic                               o_vld,
  output logic [DATA_WIDTH-1:0]              o_dat
);
  logic [1:0] r_ptr;
  logic [1:0] r_src_q;
  logic       r_valid_q;
  logic [1:0] w_sel;
  logic [1:0] w_idx;
  logic       w_any;
  logic       w_grant;

  // Scan from the pointer; the first non-empty source at or after it wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = 2'((int'(r_ptr) + k) % NUM_SRC);
      if (!w_any && !i_empty[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_grant = w_any && !i_stall && !i_rst;

  always_comb begin
    o_ren = '0;
    if (w_grant) o_ren[w_sel] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= SRC_ROUTING;
      r_src_q   <= SRC_ROUTING;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= w_grant;
      if (w_grant) begin
        r_src_q <= w_sel;
        r_ptr   <= next_src(w_sel);
      end
    end
  end

  assign o_vld = r_valid_q;
  assign o_dat = i_din[r_src_q];
endmodule

// File: rtl/forward_north_south.sv
// Vertical forwarding stage: merges routing/east/west dy-only packets, steps dy or strips it for local delivery.
// Source read to FIFO write is 1 cycle; stalls all reads while either output FIFO is full or almost full. Optional counters: FORWARD_NS_STATS_EN.
module forward_north_south import forward_north_south_pkg::*; #(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int DY_MSB       = DY_MSB_DEF,
  parameter int DY_LSB       = DY_LSB_DEF,
  parameter int BUFFER_DEPTH = 4,
  parameter int NORTH        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] din_routing,
  input  logic                    empty_routing,
  output logic                    ren_out_routing,
  input  logic [PACKET_WIDTH-1:0] din_east,
  input  logic                    empty_east,
  output logic                    ren_out_east,
  input  logic [PACKET_WIDTH-1:0] din_west,
  input  logic                    empty_west,
  output logic                    ren_out_west,
  input  logic                    ren_in_routing,
  output logic [PACKET_WIDTH-1:0] dout_routing,
  output logic                    routing_buffer_empty,
  input  logic                    ren_in_local,
  output logic [DY_LSB-1:0]       dout_local,
  output logic                    local_buffer_empty
`ifdef FORWARD_NS_STATS_EN
  ,
  output logic [15:0]             stat_local,
  output logic [15:0]             stat_forward
`endif
);
  localparam int DYW = DY_MSB - DY_LSB + 1;
  localparam logic [DYW-1:0] ADD = DYW'((NORTH != 0) ? ADD_NORTH : ADD_SOUTH);

  logic [NUM_SRC-1:0][PACKET_WIDTH-1:0] w_din;
  logic [NUM_SRC-1:0]                   w_empty;
  logic [NUM_SRC-1:0]                   w_ren;
  logic                                 w_cap_vld;
  logic [PACKET_WIDTH-1:0]              w_cap_dat;
  logic [DYW-1:0]                       w_dy;
  logic [DY_LSB-1:0]                    w_payload;
  logic                                 w_wr_local;
  logic                                 w_wr_route;
  logic [PACKET_WIDTH-1:0]              w_route_dat;
  logic                                 w_rt_full, w_rt_afull, w_lc_full, w_lc_afull;
  logic                                 w_stall;

  assign w_din[SRC_ROUTING]   = din_routing;
  assign w_din[SRC_EAST]      = din_east;
  assign w_din[SRC_WEST]      = din_west;
  assign w_empty[SRC_ROUTING] = empty_routing;
  assign w_empty[SRC_EAST]    = empty_east;
  assign w_empty[SRC_WEST]    = empty_west;
  assign ren_out_routing      = w_ren[SRC_ROUTING];
  assign ren_out_east         = w_ren[SRC_EAST];
  assign ren_out_west         = w_ren[SRC_WEST];

  // Almost-full reserves the slot for the packet already in flight from last cycle's grant.
  assign w_stall = w_rt_full | w_rt_afull | w_lc_full | w_lc_afull;

  rr_merge3 #(.DATA_WIDTH(PACKET_WIDTH)) u_merge (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_din   (w_din),
    .i_empty (w_empty),
    .i_stall (w_stall),
    .o_ren   (w_ren),
    .o_vld   (w_cap_vld),
    .o_dat   (w_cap_dat)
  );

  assign w_dy        = w_cap_dat[DY_MSB:DY_LSB];
  assign w_payload   = w_cap_dat[DY_LSB-1:0];
  assign w_wr_local  = w_cap_vld && (w_dy == '0);
  assign w_wr_route  = w_cap_vld && (w_dy != '0);
  assign w_route_dat = PACKET_WIDTH'({w_dy + ADD, w_payload});

  fifo_buffer #(.WIDTH(PACKET_WIDTH), .DEPTH(BUFFER_DEPTH)) u_routing_fifo (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (w_wr_route),
    .i_din         (w_route_dat),
    .i_rd_en       (ren_in_routing),
    .o_dout        (dout_routing),
    .o_empty       (routing_buffer_empty),
    .o_full        (w_rt_full),
    .o_almost_full (w_rt_afull)
  );

  fifo_buffer #(.WIDTH(DY_LSB), .DEPTH(BUFFER_DEPTH)) u_local_fifo (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (w_wr_local),
    .i_din         (w_payload),
    .i_rd_en       (ren_in_local),
    .o_dout        (dout_local),
    .o_empty       (local_buffer_empty),
    .o_full        (w_lc_full),
    .o_almost_full (w_lc_afull)
  );

`ifdef FORWARD_NS_STATS_EN
  logic [15:0] r_stat_local;
  logic [15:0] r_stat_forward;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_local   <= '0;
      r_stat_forward <= '0;
    end else begin
      if (w_wr_local && (r_stat_local != 16'hFFFF))   r_stat_local   <= r_stat_local + 16'd1;
      if (w_wr_route && (r_stat_forward != 16'hFFFF)) r_stat_forward <= r_stat_forward + 16'd1;
    end
  end

  assign stat_local   = r_stat_local;
  assign stat_forward = r_stat_forward;
`endif
endmodule

// File: tb/tb_forward_north_south.sv
// Randomised bench for forward_north_south: source FIFOs and expected output FIFOs are modelled with queues.
module tb_forward_north_south;
  localparam int PW = 21;
  localparam int DM = 20;
  localparam int DL = 12;
  localparam int BD = 4;
  localparam int NO = 1;

  typedef logic [PW-1:0] pkt_t;

  logic clk = 1'b0;
  logic rst;
  pkt_t din_routing, din_east, din_west, dout_routing;
  logic empty_routing, empty_east, empty_west;
  logic ren_out_routing, ren_out_east, ren_out_west;
  logic ren_in_routing, ren_in_local;
  logic routing_buffer_empty, local_buffer_empty;
  logic [DL-1:0] dout_local;
`ifdef FORWARD_NS_STATS_EN
  logic [15:0] stat_local, stat_forward;
`endif

  always #5 clk = ~clk;

  forward_north_south #(
    .PACKET_WIDTH(PW), .DY_MSB(DM), .DY_LSB(DL), .BUFFER_DEPTH(BD), .NORTH(NO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .din_routing          (din_routing),
    .empty_routing        (empty_routing),
    .ren_out_routing      (ren_out_routing),
    .din_east             (din_east),
    .empty_east           (empty_east),
    .ren_out_east         (ren_out_east),
    .din_west             (din_west),
    .empty_west           (empty_west),
    .ren_out_west         (ren_out_west),
    .ren_in_routing       (ren_in_routing),
    .dout_routing         (dout_routing),
    .routing_buffer_empty (routing_buffer_empty),
    .ren_in_local         (ren_in_local),
    .dout_local           (dout_local),
    .local_buffer_empty   (local_buffer_empty)
`ifdef FORWARD_NS_STATS_EN
    ,
    .stat_local           (stat_local),
    .stat_forward         (stat_forward)
`endif
  );

  // Source FIFOs (entries not yet read) and expected output FIFO contents.
  pkt_t          src_rt[$], src_e[$], src_w[$];
  pkt_t          exp_rt[$];
  logic [DL-1:0] exp_lc[$];
  pkt_t          exp_dout_rt;
  logic [DL-1:0] exp_dout_lc;
  logic          pend_vld;
  pkt_t          pend_pkt;
  int            ptr;
  logic [2:0]    last_ren;
  int            dut_grants;
  int            grant_seq[$];
  int            n_checks = 0;
  int            n_err = 0;
  int            cnt_local = 0;
  int            cnt_fwd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int src_size(input int s);
    case (s)
      0:       return src_rt.size();
      1:       return src_e.size();
      default: return src_w.size();
    endcase
  endfunction

  task automatic src_push(input int s, input pkt_t p);
    case (s)
      0:       src_rt.push_back(p);
      1:       src_e.push_back(p);
      default: src_w.push_back(p);
    endcase
  endtask

  task automatic src_pop(input int s, output pkt_t p);
    case (s)
      0:       begin p = src_rt.pop_front(); din_routing = p; end
      1:       begin p = src_e.pop_front();  din_east    = p; end
      default: begin p = src_w.pop_front();  din_west    = p; end
    endcase
  endtask

  // Packet transform from the decode rules, with dy as a signed integer.
  task automatic model_write(input pkt_t p);
    logic [8:0] dyf;
    int         d;
    dyf = p[DM:DL];
    if (dyf == 9'd0) begin
      exp_lc.push_back(p[DL-1:0]);
      cnt_local++;
    end else begin
      d = $signed(dyf);
      d = d + ((NO != 0) ? -1 : 1);
      exp_rt.push_back({d[8:0], p[DL-1:0]});
      cnt_fwd++;
    end
  endtask

  function automatic pkt_t rand_pkt();
    int         r;
    logic [8:0] dy;
    r = $urandom_range(0, 99);
    if (r < 40)      dy = 9'd0;
    else if (r < 55) dy = 9'd1;
    else if (r < 65) dy = 9'h1FF;
    else             dy = 9'($urandom);
    return {dy, 12'($urandom)};
  endfunction

  task automatic check_cycle();
    int         g;
    logic [2:0] exp_ren, act;
    g = -1;
    if (!rst && exp_rt.size() < BD - 1 && exp_lc.size() < BD - 1)
      for (int k = 0; k < 3; k++)
        if (g < 0 && src_size((ptr + k) % 3) > 0) g = (ptr + k) % 3;
    exp_ren = 3'b000;
    if (g >= 0) exp_ren[g] = 1'b1;
    act = {ren_out_west, ren_out_east, ren_out_routing};
    chk("ren_out", act, exp_ren);
    chk("routing_empty", routing_buffer_empty, exp_rt.size() == 0);
    chk("local_empty", local_buffer_empty, exp_lc.size() == 0);
    chk("dout_routing", dout_routing, exp_dout_rt);
    chk("dout_local", dout_local, exp_dout_lc);
    last_ren = act;
    if (act != 3'b000) begin
      dut_grants++;
      grant_seq.push_back(act[0] ? 0 : (act[1] ? 1 : 2));
    end
  endtask

  task automatic advance_model();
    pkt_t p;
    int   g;
    if (rst) begin
      src_rt.delete(); src_e.delete(); src_w.delete();
      exp_rt.delete(); exp_lc.delete();
      exp_dout_rt = '0; exp_dout_lc = '0;
      pend_vld = 1'b0; ptr = 0;
      din_routing = '0; din_east = '0; din_west = '0;
      cnt_local = 0; cnt_fwd = 0;
    end else begin
      if (ren_in_local && exp_lc.size() > 0)   exp_dout_lc = exp_lc.pop_front();
      if (ren_in_routing && exp_rt.size() > 0) exp_dout_rt = exp_rt.pop_front();
      if (pend_vld) model_write(pend_pkt);
      pend_vld = 1'b0;
      if (last_ren != 3'b000) begin
        g = last_ren[0] ? 0 : (last_ren[1] ? 1 : 2);
        if (src_size(g) > 0) begin
          src_pop(g, p);
          pend_vld = 1'b1;
          pend_pkt = p;
        end
        ptr = (g + 1) % 3;
      end
    end
  endtask

  task automatic step();
    empty_routing = (src_rt.size() == 0);
    empty_east    = (src_e.size() == 0);
    empty_west    = (src_w.size() == 0);
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    advance_model();
  endtask

  initial begin
    int g0, mism, c0, c1, c2;
    rst = 1'b1; ren_in_routing = 1'b0; ren_in_local = 1'b0;
    din_routing = '0; din_east = '0; din_west = '0;
    exp_dout_rt = '0; exp_dout_lc = '0; pend_vld = 1'b0; pend_pkt = '0;
    ptr = 0; last_ren = '0; dut_grants = 0;
    step(); step();
    chk("reset_rt_empty", routing_buffer_empty, 1);
    chk("reset_lc_empty", local_buffer_empty, 1);
    chk("reset_dout_rt", dout_routing, 0);
    chk("reset_dout_lc", dout_local, 0);
    chk("reset_ren", {ren_out_west, ren_out_east, ren_out_routing}, 0);
    rst = 1'b0;

    src_push(1, {9'd0, 12'hA5C});
    step(); step();
    chk("a5c_local_ready", local_buffer_empty, 0);
    chk("a5c_routing_idle", routing_buffer_empty, 1);
    ren_in_local = 1'b1; step(); ren_in_local = 1'b0;
    chk("a5c_dout_local", dout_local, 12'hA5C);

    ren_in_routing = 1'b1;
    src_push(0, {9'd3, 12'h123});
    repeat (3) step();
    chk("hop_plus3", dout_routing, 21'h02123);
    src_push(2, {9'h1FF, 12'h456});
    repeat (3) step();
    chk("hop_minus1", dout_routing, 21'h1FE456);

    ren_in_local = 1'b0;
    g0 = dut_grants;
    for (int i = 0; i < 8; i++) src_push(1, {9'd0, 12'($urandom)});
    repeat (12) step();
    chk("bp_grants_held", dut_grants - g0, BD);
    chk("bp_local_full", local_buffer_empty, 0);
    ren_in_local = 1'b1;
    repeat (30) step();
    chk("bp_grants_total", dut_grants - g0, 8);
    chk("bp_drained", local_buffer_empty, 1);

    src_push(1, rand_pkt());
    step();
    chk("mid_grant_east", last_ren, 3'b010);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_rt_empty", routing_buffer_empty, 1);
    chk("mid_rst_lc_empty", local_buffer_empty, 1);

    grant_seq.delete();
    for (int i = 0; i < 10; i++) begin
      src_push(0, rand_pkt()); src_push(1, rand_pkt()); src_push(2, rand_pkt());
    end
    step();
    chk("ptr_after_reset", last_ren, 3'b001);
    repeat (35) step();
    chk("rr_total", grant_seq.size(), 30);
    mism = 0; c0 = 0; c1 = 0; c2 = 0;
    foreach (grant_seq[i]) begin
      if (grant_seq[i] != i % 3) mism++;
      if (grant_seq[i] == 0) c0++;
      else if (grant_seq[i] == 1) c1++;
      else c2++;
    end
    chk("rr_order_errors", mism, 0);
    chk("rr_routing_cnt", c0, 10);
    chk("rr_east_cnt", c1, 10);
    chk("rr_west_cnt", c2, 10);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int s = 0; s < 3; s++)
        if (src_size(s) < 8 && $urandom_range(0, 99) < 30) src_push(s, rand_pkt());
      ren_in_routing = ($urandom_range(0, 99) < (((cyc / 200) % 2 == 0) ? 80 : 15));
      ren_in_local   = ($urandom_range(0, 99) < (((cyc / 150) % 2 == 0) ? 75 : 20));
      step();
    end

    ren_in_routing = 1'b1; ren_in_local = 1'b1;
    repeat (60) step();
    chk("final_rt_empty", routing_buffer_empty, 1);
    chk("final_lc_empty", local_buffer_empty, 1);
    chk("final_src_consumed", src_size(0) + src_size(1) + src_size(2), 0);
`ifdef FORWARD_NS_STATS_EN
    chk("stat_local", stat_local, cnt_local);
    chk("stat_forward", stat_forward, cnt_fwd);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
